// File: rtl/tone_gen_multi.sv
// Multi-channel square-wave tone generator with a nibble-wide write bus.
// Each channel has a shadow/active period pair and a PWM volume.

module tone_gen_ch #(
    parameter int DIV_W = 12,
    parameter int VOL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             tick,
    input  logic             wr_en,
    input  logic [1:0]       k,
    input  logic [3:0]       d,
    input  logic [VOL_W-1:0] pwm,
    output logic             sout
);
    localparam int NIB = DIV_W / 4;
    localparam int SH  = (NIB > 1) ? NIB - 1 : 1;

    logic [SH-1:0][3:0] shadow;
    logic [DIV_W-1:0]   period, cnt, commit_val;
    logic [VOL_W-1:0]   vol;
    logic               phase;

    // Writing the top nibble assembles the whole period in one step.
    always_comb begin
        commit_val = '0;
        for (int i = 0; i < NIB - 1; i++) commit_val[i*4 +: 4] = shadow[i];
        commit_val[DIV_W-1 -: 4] = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            period <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NIB - 1; i++)
                if (k == 2'(i)) shadow[i] <= d;
            if (k == 2'(NIB - 1)) period <= commit_val;
        end
    end

    generate
        if (NIB < 4) begin : g_vol
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                   vol <= '0;
                else if (wr_en && k == 2'd3)  vol <= d[VOL_W-1:0];
            end
        end else begin : g_novol
            assign vol = '1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
            sout  <= 1'b0;
        end else begin
            if (tick) begin
                if (period == '0) begin
                    cnt   <= '0;
                    phase <= 1'b0;
                end else if (cnt >= period) begin
                    cnt   <= '0;
                    phase <= ~phase;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            sout <= run & phase & (pwm < vol);
        end
    end
endmodule

module tone_gen_multi #(
    parameter int CHANNELS  = 2,
    parameter int DIV_W     = 12,
    parameter int VOL_W     = 4,
    parameter int PRESCALE  = 16,
    parameter int RST_DELAY = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WR,
    input  logic                A0,
    input  logic [3:0]          D,
    output logic [CHANNELS-1:0] SOUT,
    output logic                RDY
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(RST_DELAY + 1);

    logic [DW-1:0]    dly;
    logic [PW-1:0]    pre;
    logic [VOL_W-1:0] pwm;
    logic [3:0]       ptr;
    logic             wr_q, tick, we;

    assign tick = RDY && (pre == PW'(PRESCALE - 1));
    assign we   = WR && !wr_q && RDY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dly  <= '0;
            RDY  <= 1'b0;
            pre  <= '0;
            pwm  <= '0;
            ptr  <= '0;
            wr_q <= 1'b0;
        end else begin
            wr_q <= WR;
            if (!RDY) begin
                dly <= dly + 1'b1;
                if (dly == DW'(RST_DELAY - 1)) RDY <= 1'b1;
            end else begin
                pre <= tick ? '0 : pre + 1'b1;
                pwm <= pwm + 1'b1;
            end
            // Data writes auto-increment so a full channel loads in one burst.
            if (we) ptr <= A0 ? D : ptr + 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        tone_gen_ch #(.DIV_W(DIV_W), .VOL_W(VOL_W)) u_ch (
            .clk   (CLK),
            .rst_n (RST),
            .run   (RDY),
            .tick  (tick),
            .wr_en (we && !A0 && (ptr[3:2] == 2'(c))),
            .k     (ptr[1:0]),
            .d     (D),
            .pwm   (pwm),
            .sout  (SOUT[c])
        );
    end
endmodule

// File: tb/tb_tone_gen_multi.sv
// Directed bench for tone_gen_multi at default parameters (2 ch, 12-bit period, /16).
module tb_tone_gen_multi;
    logic       CLK = 1'b0;
    logic       RST, WR, A0;
    logic [3:0] D;
    logic [1:0] SOUT;
    logic       RDY;
    int         errors = 0;
    int         checks = 0;

    tone_gen_multi dut (
        .CLK (CLK), .RST (RST), .WR (WR), .A0 (A0), .D (D), .SOUT (SOUT), .RDY (RDY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic a0, input logic [3:0] d);
        A0 = a0; D = d; WR = 1'b1;
        cyc(1);
        WR = 1'b0;
        cyc(1);
    endtask

    task automatic count_ones(input int ch, input int n, output int ones);
        ones = 0;
        for (int c = 0; c < n; c++) begin
            cyc(1);
            if (SOUT[ch]) ones++;
        end
    endtask

    // Rise of the high phase = 1 after at least two zeros (vol 15 only leaves single zeros).
    task automatic measure(input int ch, output int per);
        int  zeros, t0;
        bit  got;
        per = -1; zeros = 0; got = 0; t0 = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc(1);
            if (SOUT[ch]) begin
                if (zeros >= 2) begin
                    if (!got) begin
                        got = 1; t0 = c;
                    end else begin
                        per = c - t0;
                        break;
                    end
                end
                zeros = 0;
            end else begin
                zeros++;
            end
        end
    endtask

    initial begin
        int per, ones, hi;
        RST = 1'b0; WR = 1'b0; A0 = 1'b0; D = 4'd0;
        cyc(3);
        check("rst_sout", SOUT, 0);
        check("rst_rdy", RDY, 0);

        // Hold-off: a pointer write on edge 3 must be dropped.
        RST = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            if (e == 3) begin WR = 1'b1; A0 = 1'b1; D = 4'd8; end
            cyc(1);
            if (e == 3) begin WR = 1'b0; A0 = 1'b0; D = 4'd0; end
            check($sformatf("holdoff_rdy_e%0d", e), RDY, (e == 5) ? 1 : 0);
            if (e < 5) check($sformatf("holdoff_sout_e%0d", e), SOUT, 0);
        end

        // Frequency: ch0 P=3, vol 15, relying on ptr still 0.
        wr(0, 4'd3); wr(0, 4'd0); wr(0, 4'd0); wr(0, 4'd15);
        measure(0, per);
        check("freq_period", per, 128);
        count_ones(0, 128, ones);
        check("freq_ones", ones, 60);
        count_ones(1, 128, ones);
        check("freq_ch1_silent", ones, 0);

        // Atomic commit.
        wr(1, 4'd0); wr(0, 4'd15);
        measure(0, per);
        check("atomic_partial", per, 128);
        wr(0, 4'd0); wr(0, 4'd0);
        measure(0, per);
        check("atomic_commit", per, 512);

        // Volume.
        wr(1, 4'd0); wr(0, 4'd3); wr(0, 4'd0); wr(0, 4'd0); wr(0, 4'd4);
        cyc(64);
        count_ones(0, 128, ones);
        check("vol4_ones", ones, 16);
        wr(1, 4'd3); wr(0, 4'd0);
        cyc(4);
        count_ones(0, 128, ones);
        check("vol0_ones", ones, 0);

        // Pointer wrap, invalid channel, held strobe.
        wr(1, 4'd3); wr(0, 4'd15);
        wr(1, 4'd15); wr(0, 4'd7);
        A0 = 1'b0; D = 4'd7; WR = 1'b1;
        cyc(10);
        WR = 1'b0;
        cyc(1);
        wr(0, 4'd0); wr(0, 4'd0);
        measure(0, per);
        check("wrap_period", per, 256);
        count_ones(1, 256, ones);
        check("wrap_ch1_silent", ones, 0);

        // Reset mid-tone on ch1.
        wr(1, 4'd4); wr(0, 4'd3); wr(0, 4'd0); wr(0, 4'd0); wr(0, 4'd15);
        measure(1, per);
        check("ch1_period", per, 128);
        hi = 0;
        for (int c = 0; c < 300 && !hi; c++) begin
            cyc(1);
            if (SOUT[1]) hi = 1;
        end
        check("ch1_high_before_rst", hi, 1);
        #2 RST = 1'b0;
        #1;
        check("midrst_sout", SOUT, 0);
        check("midrst_rdy", RDY, 0);
        RST = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            cyc(1);
            if (e >= 4) check($sformatf("rerdy_e%0d", e), RDY, (e == 5) ? 1 : 0);
        end
        count_ones(0, 512, ones);
        check("post_rst_ch0", ones, 0);
        count_ones(1, 512, ones);
        check("post_rst_ch1", ones, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
